// File: rtl/hotp_pkg.sv
// Shared types, sizes and digit formatting for the HOTP truncation back end.
// The digit format depends on HOTP_ASCII_EN (ASCII when defined, raw BCD otherwise).
package hotp_pkg;

  localparam int unsigned TRUNC_BITS = 31;
  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned BCD_BITS   = 4 * BCD_DIGITS;
  localparam int unsigned CONV_STEPS = 31;
  localparam int unsigned STEP_W     = 5;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEL  = 2'd1,
    CONV = 2'd2,
    EMIT = 2'd3
  } state_e;

  function automatic logic [3:0] bcd_nibble(input logic [BCD_BITS-1:0] bcd,
                                            input logic [3:0]          idx);
    return 4'(bcd >> (32'(idx) * 32'd4));
  endfunction

  function automatic logic [7:0] fmt_digit(input logic [3:0] d);
`ifdef HOTP_ASCII_EN
    return 8'h30 | {4'h0, d};
`else
    return {4'h0, d};
`endif
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Serial double-dabble: 31-bit binary to 10-digit BCD, one shift per step.
module bcd_dabble
  import hotp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [TRUNC_BITS-1:0] bin,
  output logic [BCD_BITS-1:0]   bcd,
  output logic [BCD_BITS-1:0]   bcd_nxt_c,
  output logic                  done_c
);

  logic [TRUNC_BITS-1:0] bin_q, bin_d;
  logic [BCD_BITS-1:0]   bcd_q, bcd_d;
  logic [STEP_W-1:0]     cnt_q, cnt_d;
  logic [BCD_BITS-1:0]   adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_nxt_c = BCD_BITS'({adj, bin_q[TRUNC_BITS-1]});
    done_c    = step && (cnt_q == STEP_W'(CONV_STEPS - 1));

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
    end else if (step) begin
      bin_d = {bin_q[TRUNC_BITS-2:0], 1'b0};
      bcd_d = bcd_nxt_c;
      cnt_d = cnt_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/hotp_truncate.sv
// HOTP back end: digest buffer, dynamic truncation, decimal conversion, digit stream.
// HOTP_ASCII_EN selects ASCII digits on dout; otherwise raw BCD nibbles.
module hotp_truncate
  import hotp_pkg::*;
#(
  parameter int unsigned HASH_BITS = 160,
  parameter int unsigned DIGITS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       busy
);

  localparam int unsigned HASH_BYTES = HASH_BITS / 8;
  localparam int unsigned CNT_W      = $clog2(HASH_BYTES);

  state_e                state_q, state_d;
  logic [HASH_BITS-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            k_q, k_d;
  logic                  din_ready_q, din_ready_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;
  logic [7:0]            dout_q, dout_d;
  logic                  busy_q, busy_d;

  logic                  load_c, step_c, done_c;
  logic [3:0]            off_c;
  logic [TRUNC_BITS-1:0] p_c;
  logic [BCD_BITS-1:0]   bcd, bcd_nxt_c;

  // Last byte sits in the low byte of the buffer; byte i is big-endian from the top.
  assign off_c = buf_q[3:0];
  assign p_c   = TRUNC_BITS'(buf_q >> (HASH_BITS - 32'd32 - 32'd8 * 32'(off_c)));

  bcd_dabble u_dabble (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .step      (step_c),
    .bin       (p_c),
    .bcd       (bcd),
    .bcd_nxt_c (bcd_nxt_c),
    .done_c    (done_c)
  );

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_d       = dout_q;
    load_c       = 1'b0;
    step_c       = 1'b0;

    case (state_q)
      LOAD: begin
        if (din_valid && din_ready_q) begin
          buf_d = {buf_q[HASH_BITS-9:0], din};
          if (cnt_q == CNT_W'(HASH_BYTES - 1)) state_d = SEL;
          else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEL: begin
        load_c  = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        step_c = 1'b1;
        // First digit comes straight from the final conversion step.
        if (done_c) begin
          state_d      = EMIT;
          k_d          = 4'(DIGITS - 1);
          dout_valid_d = 1'b1;
          dout_last_d  = (DIGITS == 1);
          dout_d       = fmt_digit(bcd_nibble(bcd_nxt_c, 4'(DIGITS - 1)));
        end
      end
      EMIT: begin
        if (dout_valid_q && dout_ready) begin
          if (k_q == 4'd0) begin
            state_d      = LOAD;
            cnt_d        = '0;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            dout_d       = 8'h00;
          end else begin
            k_d         = k_q - 4'd1;
            dout_last_d = (k_q == 4'd1);
            dout_d      = fmt_digit(bcd_nibble(bcd, k_q - 4'd1));
          end
        end
      end
      default: state_d = LOAD;
    endcase

    din_ready_d = (state_d == LOAD);
    busy_d      = !((state_d == LOAD) && (cnt_d == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      buf_q        <= '0;
      cnt_q        <= '0;
      k_q          <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_q       <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout       = dout_q;
  assign busy       = busy_q;

endmodule
